// File: rtl/alu_io_pkg.sv
// Shared types and constants for the ALU lab board operand-entry path.
package alu_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } entry_state_t;

    localparam int BCD_MAX      = 9;
    localparam int DECIMAL_BASE = 10;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one raw push button; emits a level and a
// one-cycle press pulse on the level's rising transition.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    // Level flips on the edge where the mismatch run reaches DEBOUNCE_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign press = r_level & ~r_level_d;

endmodule

// File: rtl/bcd_entry.sv
// Decimal operand entry: debounced ENTER/CLEAR, MSD-first BCD accumulation
// with saturation, and a valid/ready hand-off of the completed operand.
module bcd_entry
    import alu_io_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DIGITS          = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       digit_in,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] value_out,
    output logic             value_valid,
    input  logic             value_ready,
    output logic [WIDTH-1:0] acc_out,
    output logic [1:0]       digit_count,
    output logic             digit_err,
    output logic             overflow
);

    localparam int SUMW = WIDTH + $clog2(DECIMAL_BASE);

    entry_state_t     r_state;
    entry_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_value;
    logic [1:0]       r_count;
    logic             r_valid;
    logic             r_err;
    logic             r_ovf;

    logic             w_enter_press;
    logic             w_clear_press;
    logic             w_digit_ok;
    logic             w_do_digit;
    logic             w_do_err;
    logic             w_do_xfer;
    logic             w_last;
    logic             w_sat;
    logic [SUMW-1:0]  w_acc_ext;
    logic [SUMW-1:0]  w_sum;
    logic [WIDTH-1:0] w_acc_nxt;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_enter),
        .level (),
        .press (w_enter_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clear),
        .level (),
        .press (w_clear_press)
    );

    // acc*10 + digit at widened precision so saturation can be detected.
    assign w_acc_ext  = SUMW'(r_acc);
    assign w_sum      = (w_acc_ext << 3) + (w_acc_ext << 1) + SUMW'(digit_in);
    assign w_sat      = |w_sum[SUMW-1:WIDTH];
    assign w_acc_nxt  = w_sat ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    assign w_digit_ok = (digit_in <= 4'(BCD_MAX));
    assign w_last     = (r_count == 2'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_clear_press) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, ENTRY: if (w_do_digit) w_state_nxt = w_last ? HOLD : ENTRY;
                HOLD:        if (w_do_xfer)  w_state_nxt = IDLE;
                default:     w_state_nxt = IDLE;
            endcase
        end
    end

    // Clear outranks both a digit entry and a handshake on the same edge.
    always_comb begin
        w_do_digit = 1'b0;
        w_do_err   = 1'b0;
        w_do_xfer  = 1'b0;
        if (!w_clear_press) begin
            if (r_state == HOLD) begin
                w_do_xfer = value_ready;
            end else if (w_enter_press) begin
                w_do_digit = w_digit_ok;
                w_do_err   = ~w_digit_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_value <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_err <= w_do_err;
            if (w_clear_press || w_do_xfer) begin
                r_acc   <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
                r_valid <= 1'b0;
            end else if (w_do_digit) begin
                r_acc   <= w_acc_nxt;
                r_count <= r_count + 2'd1;
                if (w_sat) r_ovf <= 1'b1;
                if (w_last) begin
                    r_value <= w_acc_nxt;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign value_out   = r_value;
    assign value_valid = r_valid;
    assign acc_out     = r_acc;
    assign digit_count = r_count;
    assign digit_err   = r_err;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_bcd_entry.sv
// Bench for bcd_entry: 8-bit and 4-bit instances share stimulus and are
// checked against a decimal-arithmetic operand model.
module tb_bcd_entry;

    localparam int DB     = 4;
    localparam int DIGITS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic       btn_enter, btn_clear, value_ready;

    logic [7:0] vo8, acc8;
    logic [3:0] vo4, acc4;
    logic [1:0] cnt8, cnt4;
    logic       vv8, vv4, err8, err4, ov8, ov4;

    always #5 clk = ~clk;

    bcd_entry #(.WIDTH(8), .DIGITS(DIGITS), .DEBOUNCE_CYCLES(DB)) dut8 (
        .clk(clk), .rst(rst), .digit_in(digit_in), .btn_enter(btn_enter),
        .btn_clear(btn_clear), .value_out(vo8), .value_valid(vv8),
        .value_ready(value_ready), .acc_out(acc8), .digit_count(cnt8),
        .digit_err(err8), .overflow(ov8));

    bcd_entry #(.WIDTH(4), .DIGITS(DIGITS), .DEBOUNCE_CYCLES(DB)) dut4 (
        .clk(clk), .rst(rst), .digit_in(digit_in), .btn_enter(btn_enter),
        .btn_clear(btn_clear), .value_out(vo4), .value_valid(vv4),
        .value_ready(value_ready), .acc_out(acc4), .digit_count(cnt4),
        .digit_err(err4), .overflow(ov4));

    int checks   = 0;
    int failures = 0;

    // Operand model: index 0 = 8-bit instance, index 1 = 4-bit instance.
    int m_acc[2];
    int m_vout[2];
    bit m_ovf[2];
    int m_cnt;
    bit m_valid;
    bit m_err;
    int maxv[2] = '{255, 15};

    wire [31:0] w_obs = {acc8, cnt8, vv8, ov8, vo8, acc4, cnt4, vv4, ov4, vo4};
    wire [1:0]  w_err = {err8, err4};

    function automatic logic [31:0] exp_vec();
        return {8'(m_acc[0]), 2'(m_cnt), m_valid, m_ovf[0], 8'(m_vout[0]),
                4'(m_acc[1]), 2'(m_cnt), m_valid, m_ovf[1], 4'(m_vout[1])};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_vout[k] = 0; m_ovf[k] = 0;
        end
        m_cnt = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic m_clear();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_ovf[k] = 0;
        end
        m_cnt = 0; m_valid = 0;
    endtask

    task automatic m_enter(input int d);
        int s;
        if (m_valid) return;
        if (d > 9) begin
            m_err = 1;
            return;
        end
        m_cnt++;
        for (int k = 0; k < 2; k++) begin
            s = m_acc[k] * 10 + d;
            if (s > maxv[k]) begin
                m_acc[k] = maxv[k];
                m_ovf[k] = 1;
            end else begin
                m_acc[k] = s;
            end
            if (m_cnt == DIGITS) m_vout[k] = m_acc[k];
        end
        if (m_cnt == DIGITS) m_valid = 1;
    endtask

    task automatic m_xfer();
        if (m_valid) m_clear();
    endtask

    // Hold buttons stable-high until the update edge (DB+3 edges), then model it.
    task automatic press(input bit en, input bit cl, input int d, input bit rdy);
        bit was_valid;
        digit_in = 4'(d); btn_enter = en; btn_clear = cl;
        tick(DB + 2);
        value_ready = rdy;
        tick(1);
        value_ready = 1'b0;
        was_valid = m_valid;
        m_err = 0;
        if (cl) begin
            m_clear();
        end else begin
            if (en) m_enter(d);
            if (rdy && was_valid) m_xfer();
        end
    endtask

    task automatic release_btns();
        btn_enter = 1'b0; btn_clear = 1'b0;
        tick(DB + 4);
        m_err = 0;
    endtask

    task automatic handshake();
        value_ready = 1'b1;
        tick(1);
        value_ready = 1'b0;
        m_xfer();
    endtask

    task automatic test_reset();
        rst = 1'b1; digit_in = 4'd0; btn_enter = 1'b0; btn_clear = 1'b0; value_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        m_reset();
        tick(1);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL reset_state got=%h exp=%h", w_obs, exp_vec()); end
        checks++; if (w_err !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", w_err); end
    endtask

    task automatic test_basic();
        press(1, 0, 4, 0);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL basic_d4 got=%h exp=%h", w_obs, exp_vec()); end
        release_btns();
        press(1, 0, 2, 0);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL basic_d42 got=%h exp=%h", w_obs, exp_vec()); end
        release_btns();
        handshake();
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL basic_xfer got=%h exp=%h", w_obs, exp_vec()); end
    endtask

    task automatic test_saturate();
        press(1, 0, 1, 0);
        release_btns();
        press(1, 0, 7, 0);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL sat_17 got=%h exp=%h", w_obs, exp_vec()); end
        release_btns();
        handshake();
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL sat_xfer got=%h exp=%h", w_obs, exp_vec()); end
    endtask

    task automatic test_digit_err();
        press(1, 0, 11, 0);
        checks++; if (w_err !== 2'b11) begin failures++; $display("FAIL err_pulse got=%b exp=11", w_err); end
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL err_state got=%h exp=%h", w_obs, exp_vec()); end
        tick(1);
        checks++; if (w_err !== 2'b00) begin failures++; $display("FAIL err_one_cycle got=%b exp=00", w_err); end
        release_btns();
    endtask

    task automatic test_bounce();
        digit_in = 4'd5;
        for (int i = 0; i < 5; i++) begin
            btn_enter = 1'b1; tick(2);
            btn_enter = 1'b0; tick(2);
        end
        tick(10);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL bounce_nopress got=%h exp=%h", w_obs, exp_vec()); end
        btn_enter = 1'b1;
        tick(DB + 2);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL bounce_early got=%h exp=%h", w_obs, exp_vec()); end
        tick(1);
        m_enter(5);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL bounce_latency got=%h exp=%h", w_obs, exp_vec()); end
        release_btns();
    endtask

    task automatic test_clear();
        press(0, 1, 0, 0);
        release_btns();
        press(1, 0, 3, 0);
        release_btns();
        press(1, 1, 5, 0);
        checks++; if (w_obs !== exp_vec() || w_err !== 2'b00) begin failures++; $display("FAIL clear_vs_enter got=%h exp=%h", w_obs, exp_vec()); end
        release_btns();
        press(1, 0, 1, 0); release_btns();
        press(1, 0, 2, 0); release_btns();
        press(0, 1, 0, 1);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL clear_vs_ready got=%h exp=%h", w_obs, exp_vec()); end
        release_btns();
    endtask

    task automatic test_hold();
        press(1, 0, 9, 0); release_btns();
        press(1, 0, 9, 0); release_btns();
        tick(10);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL hold_stable got=%h exp=%h", w_obs, exp_vec()); end
        press(1, 0, 9, 0);
        checks++; if (w_obs !== exp_vec() || w_err !== 2'b00) begin failures++; $display("FAIL hold_enter_ignored got=%h exp=%h", w_obs, exp_vec()); end
        release_btns();
        handshake();
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL hold_xfer got=%h exp=%h", w_obs, exp_vec()); end
    endtask

    task automatic test_reset_mid();
        press(1, 0, 3, 0); release_btns();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        m_reset();
        checks++; if (w_obs !== exp_vec() || w_err !== 2'b00) begin failures++; $display("FAIL reset_mid got=%h exp=%h", w_obs, exp_vec()); end
    endtask

    task automatic test_held_reset();
        digit_in = 4'd6; btn_enter = 1'b1; rst = 1'b1;
        tick(3);
        rst = 1'b0;
        m_reset();
        tick(DB + 2);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL held_early got=%h exp=%h", w_obs, exp_vec()); end
        tick(1);
        m_enter(6);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL held_press got=%h exp=%h", w_obs, exp_vec()); end
        tick(20);
        checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL held_single got=%h exp=%h", w_obs, exp_vec()); end
        release_btns();
        press(0, 1, 0, 0); release_btns();
    endtask

    task automatic test_random();
        int d;
        for (int op = 0; op < 6; op++) begin
            if ($urandom_range(3) == 0) begin
                d = 10 + $urandom_range(5);
                press(1, 0, d, 0);
                checks++; if (w_err !== {m_err, m_err} || w_obs !== exp_vec()) begin failures++; $display("FAIL rnd_err op%0d got=%h/%b exp=%h", op, w_obs, w_err, exp_vec()); end
                release_btns();
            end
            for (int j = 0; j < DIGITS; j++) begin
                d = $urandom_range(9);
                press(1, 0, d, 0);
                checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL rnd_digit op%0d d%0d got=%h exp=%h", op, j, w_obs, exp_vec()); end
                release_btns();
            end
            tick($urandom_range(5));
            if ($urandom_range(1) == 1) begin
                press(1, 0, $urandom_range(9), 0);
                release_btns();
            end
            checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL rnd_hold op%0d got=%h exp=%h", op, w_obs, exp_vec()); end
            handshake();
            checks++; if (w_obs !== exp_vec()) begin failures++; $display("FAIL rnd_xfer op%0d got=%h exp=%h", op, w_obs, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_digit_err();
        test_bounce();
        test_clear();
        test_hold();
        test_reset_mid();
        test_held_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_entry.md
Name: bcd_entry

Overview:
Operand-entry front end for the ALU lab board, feeding the board in the opposite direction to the binary-to-decimal display path. The user sets a decimal digit on switches and presses ENTER; the block debounces the button and accumulates the digits MSD-first into a binary value. After DIGITS digits it presents the value to the ALU operand register with a valid/ready handshake.

Parameters:
WIDTH, 4, width of binary value_out / acc_out
DIGITS, 2, decimal digits per operand (1..3)
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to change a debounced button level (>=2)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
digit_in  input  4  BCD digit from switches; valid range 0..9
btn_enter  input  1  raw ENTER push button, active-high, asynchronous and bouncing
btn_clear  input  1  raw CLEAR push button, active-high, asynchronous and bouncing
value_out  output  WIDTH  completed operand (binary); held while value_valid
value_valid  output  1  operand available
value_ready  input  1  consumer accepts operand
acc_out  output  WIDTH  running accumulator, for live 7-seg display
digit_count  output  2  digits accepted in the current operand
digit_err  output  1  1-cycle pulse: ENTER pressed with digit_in > 9
overflow  output  1  sticky per operand: accumulator saturated

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; acc=0; digit_count=0; value_valid=0; value_out=0; digit_err=0; overflow=0; debouncer sync flops, counters and levels=0.
- Debounce, identical for both buttons:
  - 2-flop synchronizer.
  - Counter runs while the synced sample differs from the debounced level and clears when they match.
  - The level flips at the edge where the count reaches DEBOUNCE_CYCLES.
  - Press = 1-cycle pulse on the level's 0->1 transition.
  - Raw stable-high to acc_out update = exactly DEBOUNCE_CYCLES+3 clk edges.
  - Glitches shorter than DEBOUNCE_CYCLES samples produce no press.
  - A button held through reset release produces exactly one press.
- FSM states: IDLE, ENTRY, HOLD.
  - IDLE/ENTRY, enter press with digit_in<=9:
    - acc <= acc*10 + digit_in; digit_count++.
    - Compute at WIDTH+4 bits. If the result > 2^WIDTH-1, acc <= all-ones and overflow <= 1.
    - IDLE->ENTRY.
    - When digit_count reaches DIGITS: ->HOLD, value_out<=new acc, value_valid<=1, all on the same edge.
  - enter press with digit_in>9: digit_err=1 for one cycle; acc, count and state unchanged.
  - HOLD:
    - value_valid=1 and value_out stable until a clk edge with value_ready=1.
    - On that edge: ->IDLE; acc, digit_count, overflow <= 0; value_valid <= 0.
    - value_out keeps its last value after the transfer.
    - Enter presses in HOLD are ignored (no digit_err).
  - Clear press in any state: ->IDLE; acc, digit_count, overflow, value_valid <= 0.
    - Clear wins over a simultaneous enter press.
    - Clear wins over a simultaneous handshake; the transfer is not counted.
- acc_out = acc, registered; zero-latency view of the accumulator.
- value_ready is don't-care outside HOLD.
- Reset mid-entry discards partial digits; no residual valid.

Decomposition:
- Package alu_io_pkg:
  - typedef enum logic [1:0] entry_state_t {IDLE, ENTRY, HOLD}
  - localparam BCD_MAX=9
  - localparam DECIMAL_BASE=10
- One sub-module, button_debounce (params DEBOUNCE_CYCLES; ports clk, rst, raw, level, press), instantiated twice.
- Multiply-by-10 written as (acc<<3)+(acc<<1) inside bcd_entry.

Test Plan:
- WIDTH=8, DIGITS=2, DB=4: enter 4 then 2, ready=1 -> acc_out 4 then 42; value_out=0x2A, valid one cycle, overflow=0, then IDLE.
- WIDTH=4, DIGITS=2: enter 1, 7 -> acc 1 then 15 (saturated), overflow=1, value_out=0xF, valid=1.
- Bounce: btn_enter toggles every 2 cycles for 20 cycles, then low -> no acc change; then held high -> single update exactly 7 edges after stable rise.
- digit_in=0xB with enter -> digit_err high 1 cycle, digit_count stays 0, state IDLE.
- Enter 3, then clear pressed simultaneously with enter(5) -> acc=0, digit_count=0, valid=0.
- HOLD with value_ready=0 for 10 cycles plus an extra enter(9) -> value_out unchanged, valid held; ready=1 -> valid drops next edge, acc_out=0; rst asserted mid-entry -> all outputs 0.
